// File: rtl/digit_mux_pkg.sv
// Shared types and constants for the seven-segment digit multiplexing scheduler.
package digit_mux_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } mux_state_e;

    localparam int NIBBLE_W = 4;

    // Wide enough for any practical digit count; users slice off NUM_DIGITS bits.
    localparam int MAX_DIGITS = 32;
    localparam logic [MAX_DIGITS-1:0] DIGITS_OFF = '1;

endpackage

// File: rtl/mux_phase_timer.sv
// Phase timer shared by the blank and dwell phases: counts up from zero after
// each restart and flags the cycle on which it reaches the phase's last count.
module mux_phase_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic [CNT_W-1:0] last,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (restart) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign done = (cnt_q == last);

endmodule

// File: rtl/digit_mux_scheduler.sv
// Time-multiplexes one shared hex-to-segment decoder across NUM_DIGITS common-anode
// digits. Define DIGIT_MUX_BLANK_EN to insert anti-ghosting blank time before each digit.
module digit_mux_scheduler
    import digit_mux_pkg::*;
#(
    parameter int NUM_DIGITS   = 2,
    parameter int DWELL_CYCLES = 262144,
    parameter int BLANK_CYCLES = 4096
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] digit_val,
    input  logic [NUM_DIGITS-1:0]          digit_en,
    input  logic                           load,
    output logic                           load_ack,
    output logic [NIBBLE_W-1:0]            active_val,
    output logic [NUM_DIGITS-1:0]          anode_n,
    output logic                           frame_start
);

    localparam int MAX_PHASE = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W     = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;
    localparam int SLOT_W    = $clog2(NUM_DIGITS);
    localparam int VAL_W     = NIBBLE_W * NUM_DIGITS;

    localparam logic [CNT_W-1:0]      DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
`ifdef DIGIT_MUX_BLANK_EN
    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
`endif
    localparam logic [SLOT_W-1:0]     SLOT_LAST  = SLOT_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ALL_OFF    = DIGITS_OFF[NUM_DIGITS-1:0];

    mux_state_e              state_q, state_d;
    logic [SLOT_W-1:0]       slot_q, slot_d, next_slot;
    logic                    start_q;
    logic [VAL_W-1:0]        disp_q, shadow_q;
    logic                    pend_q;
    logic                    restart, done, enter, frame_d, commit;
    logic [CNT_W-1:0]        phase_last;
    logic [NUM_DIGITS-1:0]   anode_d;
    logic [NIBBLE_W-1:0]     active_d;

    mux_phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .restart(restart),
        .last   (phase_last),
        .done   (done)
    );

`ifdef DIGIT_MUX_BLANK_EN
    assign phase_last = (state_q == BLANK) ? BLANK_LAST : DWELL_LAST;
`else
    assign phase_last = DWELL_LAST;
`endif

    assign next_slot = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);

    // start_q marks the first edge after reset as an entry into slot 0, so the
    // opening frame lines up with every later frame.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        restart = 1'b0;
        enter   = 1'b0;
        if (start_q) begin
`ifdef DIGIT_MUX_BLANK_EN
            state_d = BLANK;
`else
            state_d = DRIVE;
`endif
            restart = 1'b1;
            enter   = 1'b1;
        end else begin
`ifdef DIGIT_MUX_BLANK_EN
            if (state_q == BLANK) begin
                if (done) begin
                    state_d = DRIVE;
                    restart = 1'b1;
                end
            end else if (done) begin
                state_d = BLANK;
                slot_d  = next_slot;
                restart = 1'b1;
                enter   = 1'b1;
            end
`else
            if (done) begin
                state_d = DRIVE;
                slot_d  = next_slot;
                restart = 1'b1;
                enter   = 1'b1;
            end
`endif
        end
    end

    assign frame_d = enter && (slot_d == '0);
    assign commit  = frame_d && pend_q;

    // Outputs are computed from the state being entered so they can be registered
    // without lagging the FSM by a cycle.
    always_comb begin
        anode_d = ALL_OFF;
        if (state_d == DRIVE && digit_en[slot_d]) begin
            anode_d[slot_d] = 1'b0;
        end
        active_d = active_val;
        if (commit) begin
            active_d = shadow_q[NIBBLE_W-1:0];
        end else if (enter) begin
            active_d = disp_q[slot_d*NIBBLE_W +: NIBBLE_W];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= BLANK;
            slot_q      <= '0;
            start_q     <= 1'b1;
            disp_q      <= '0;
            shadow_q    <= '0;
            pend_q      <= 1'b0;
            anode_n     <= ALL_OFF;
            active_val  <= '0;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            start_q     <= 1'b0;
            anode_n     <= anode_d;
            active_val  <= active_d;
            load_ack    <= commit;
            frame_start <= frame_d;
            if (load) begin
                shadow_q <= digit_val;
            end
            if (commit) begin
                disp_q <= shadow_q;
            end
            // A load on the commit edge wins, keeping its new value pending.
            if (load) begin
                pend_q <= 1'b1;
            end else if (commit) begin
                pend_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_digit_mux_scheduler.sv
// Directed bench for digit_mux_scheduler with NUM_DIGITS=2, DWELL=4, BLANK=2; expectations
// follow whichever build of DIGIT_MUX_BLANK_EN is compiled.
module tb_digit_mux_scheduler;

`ifdef DIGIT_MUX_BLANK_EN
    localparam int BLK = 2;
`else
    localparam int BLK = 0;
`endif
    localparam int DW    = 4;
    localparam int PHASE = BLK + DW;
    localparam int FRAME = 2 * PHASE;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] digit_val;
    logic [1:0] digit_en;
    logic       load;
    logic       load_ack;
    logic [3:0] active_val;
    logic [1:0] anode_n;
    logic       frame_start;

    int compare_count = 0;
    int fail_count    = 0;
    int cycle_no      = 0;

    digit_mux_scheduler #(
        .NUM_DIGITS  (2),
        .DWELL_CYCLES(DW),
        .BLANK_CYCLES(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digit_val  (digit_val),
        .digit_en   (digit_en),
        .load       (load),
        .load_ack   (load_ack),
        .active_val (active_val),
        .anode_n    (anode_n),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s cycle %0d: observed %0h expected %0h",
                     tag, cycle_no, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic [7:0] val);
        load      = ld;
        digit_val = val;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Slot k occupies PHASE cycles of each frame; its anode is low after BLK cycles.
    function automatic logic [1:0] expAnode(input int c, input logic [1:0] en);
        int slot;
        int ph;
        slot     = (c % FRAME) / PHASE;
        ph       = c % PHASE;
        expAnode = 2'b11;
        if (ph >= BLK && en[slot]) expAnode[slot] = 1'b0;
    endfunction

    function automatic logic [3:0] expActive(input int c, input logic [7:0] v1,
                                             input logic [7:0] v2);
        logic [7:0] d;
        int slot;
        d         = (c >= 2 * FRAME) ? v2 : (c >= FRAME) ? v1 : 8'h00;
        slot      = (c % FRAME) / PHASE;
        expActive = (slot == 1) ? d[7:4] : d[3:0];
    endfunction

    task automatic runScenario(input int l1c, input logic [7:0] l1v, input int l2c,
                               input logic [7:0] l2v, input logic [1:0] en,
                               input logic [7:0] v1, input bit ack1,
                               input logic [7:0] v2, input bit ack2, input int rst_cycle);
        bit running;
        reset    = 1'b1;
        digit_en = en;
        applyStimulus(1'b0, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset   = 1'b0;
        running = 1'b1;
        for (int c = 0; c <= 2 * FRAME && running; c++) begin
            stepCycle();
            cycle_no = c;
            checkOutput("anode_n", 32'(anode_n), 32'(expAnode(c, en)));
            checkOutput("frame_start", 32'(frame_start), 32'((c % FRAME) == 0));
            checkOutput("load_ack", 32'(load_ack),
                        32'((c == FRAME && ack1) || (c == 2 * FRAME && ack2)));
            checkOutput("active_val", 32'(active_val), 32'(expActive(c, v1, v2)));
            if (c == rst_cycle) begin
                #2 reset = 1'b1;
                #1;
                checkOutput("async_anode_n", 32'(anode_n), 32'h3);
                checkOutput("async_active_val", 32'(active_val), 32'h0);
                checkOutput("async_load_ack", 32'(load_ack), 32'h0);
                checkOutput("async_frame_start", 32'(frame_start), 32'h0);
                checkOutput("async_pend", 32'(dut.pend_q), 32'h0);
                running = 1'b0;
            end else if (c == l1c) begin
                applyStimulus(1'b1, l1v);
            end else if (c == l2c) begin
                applyStimulus(1'b1, l2v);
            end else begin
                applyStimulus(1'b0, 8'hC6);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        digit_en  = 2'b11;
        load      = 1'b0;
        digit_val = 8'h00;
        #2;
        checkOutput("reset_anode_n", 32'(anode_n), 32'h3);
        checkOutput("reset_active_val", 32'(active_val), 32'h0);
        checkOutput("reset_load_ack", 32'(load_ack), 32'h0);
        checkOutput("reset_frame_start", 32'(frame_start), 32'h0);

        $display("[TB] free run");
        runScenario(-1, 8'h00, -1, 8'h00, 2'b11, 8'h00, 1'b0, 8'h00, 1'b0, -1);
        $display("[TB] single load 0x3A");
        runScenario(3, 8'h3A, -1, 8'h00, 2'b11, 8'h3A, 1'b1, 8'h3A, 1'b0, -1);
        $display("[TB] two loads, last wins");
        runScenario(3, 8'h11, 5, 8'h22, 2'b11, 8'h22, 1'b1, 8'h22, 1'b0, -1);
        $display("[TB] load on commit edge");
        runScenario(3, 8'h44, FRAME - 1, 8'h55, 2'b11, 8'h44, 1'b1, 8'h55, 1'b1, -1);
        $display("[TB] digit 1 disabled");
        runScenario(-1, 8'h00, -1, 8'h00, 2'b01, 8'h00, 1'b0, 8'h00, 1'b0, -1);
        $display("[TB] async reset while digit 1 driven");
        runScenario(3, 8'h77, -1, 8'h00, 2'b11, 8'h00, 1'b0, 8'h00, 1'b0, PHASE + BLK + 1);
        runScenario(-1, 8'h00, -1, 8'h00, 2'b11, 8'h00, 1'b0, 8'h00, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
